// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: word size,
// sequential PC step, FSM state encoding and a saturating increment helper.
package fetch_unit_pkg;

    localparam int WORD        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_OUT  = 2'd3
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_gen.sv
// Next-PC selection for the fetch unit: a redirect wins (target word-aligned),
// otherwise advance by one instruction when decode consumes, otherwise hold.
module pc_next_gen
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH       = WORD,
    parameter int INSTR_BYTES = fetch_unit_pkg::INSTR_BYTES
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             advance,
    output logic [WIDTH-1:0] pc_next
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(3);

    // Priority mux; the increment wraps modulo 2^WIDTH.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc & ~ALIGN_MASK;
        end else if (advance) begin
            pc_next = pc + STEP;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one request outstanding to
// instruction memory and hands each instruction (with PC and PC+4) to decode.
// Redirects flush held state; a response already in flight is dropped.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH       = WORD,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               INSTR_BYTES = fetch_unit_pkg::INSTR_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_pc_plus4
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic             r_drop;
    logic             w_drop_next;
    logic             w_advance;
    logic             w_capture;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_if_pc;
    logic [WIDTH-1:0] r_if_pc_plus4;

    assign w_advance = (r_state == FETCH_OUT) && id_ready;

    pc_next_gen #(
        .WIDTH       (WIDTH),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_pc_next_gen (
        .pc          (r_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .advance     (w_advance),
        .pc_next     (w_pc_next)
    );

    // FSM state, PC and drop flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH_IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_drop  <= w_drop_next;
        end
    end

    // Next-state and drop-flag logic; a redirect always lands in REQ unless a
    // request to the old address is (or becomes) outstanding.
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_capture    = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                w_state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_gnt) begin
                    w_state_next = FETCH_WAIT;
                    w_drop_next  = redirect;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    w_drop_next  = 1'b0;
                    w_state_next = FETCH_REQ;
                    if (!r_drop && !redirect) begin
                        w_state_next = FETCH_OUT;
                        w_capture    = 1'b1;
                    end
                end else if (redirect) begin
                    w_drop_next = 1'b1;
                end
            end
            FETCH_OUT: begin
                if (redirect || id_ready) begin
                    w_state_next = FETCH_REQ;
                end
            end
            default: begin
                w_state_next = FETCH_IDLE;
                w_drop_next  = 1'b0;
            end
        endcase
    end

    // Output holding registers, loaded only when a live response arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr       <= '0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
        end else if (w_capture) begin
            r_instr       <= imem_rdata;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= r_pc + STEP;
        end
    end

    assign imem_req    = (r_state == FETCH_REQ);
    assign imem_addr   = r_pc;
    assign if_valid    = (r_state == FETCH_OUT);
    assign if_instr    = r_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == FETCH_REQ) && !imem_gnt) ||
                     (r_state == FETCH_WAIT) ||
                     ((r_state == FETCH_OUT) && !id_ready);

    // Saturating count of cycles spent waiting on memory or on decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a reset-mid-transaction
// sequence, and a randomized run against a transaction-level PC/memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] exp_st;
`endif

    int errs   = 0;
    int checks = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory contents as a function of word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rr;
        logic [31:0] rp;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        stl;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rr, input logic [31:0] rp, input logic rdy,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep, input logic st);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rd = rd; v.rr = rr; v.rp = rp; v.rdy = rdy;
        v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pc = ep; v.stl = st;
        return v;
    endfunction

    vec_t vt [26];

    task automatic drive_zero();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; id_ready = 0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] paddr;
        logic [31:0] prev_addr;
        logic        pending;
        logic        prev_hold;
        int          dly;
        int          ndel;

        // Each row: inputs for one cycle and outputs expected in that cycle.
        vt[0]  = mk(0,0,32'h0,       0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        0);
        vt[1]  = mk(1,0,32'h0,       0,32'h0,       0, 1,32'h0,       0,32'h0,       32'h0,        0);
        vt[2]  = mk(0,1,32'h20080005,0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[3]  = mk(0,0,32'h0,       0,32'h0,       0, 0,32'h0,       1,32'h20080005,32'h0,        1);
        vt[4]  = mk(0,0,32'h0,       0,32'h0,       0, 0,32'h0,       1,32'h20080005,32'h0,        1);
        vt[5]  = mk(0,0,32'h0,       0,32'h0,       0, 0,32'h0,       1,32'h20080005,32'h0,        1);
        vt[6]  = mk(0,0,32'h0,       0,32'h0,       0, 0,32'h0,       1,32'h20080005,32'h0,        1);
        vt[7]  = mk(0,0,32'h0,       0,32'h0,       1, 0,32'h0,       1,32'h20080005,32'h0,        0);
        vt[8]  = mk(1,0,32'h0,       0,32'h0,       0, 1,32'h4,       0,32'h0,       32'h0,        0);
        vt[9]  = mk(0,1,32'h11111111,0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[10] = mk(0,0,32'h0,       0,32'h0,       1, 0,32'h0,       1,32'h11111111,32'h4,        0);
        vt[11] = mk(0,0,32'h0,       0,32'h0,       0, 1,32'h8,       0,32'h0,       32'h0,        1);
        vt[12] = mk(0,0,32'h0,       0,32'h0,       0, 1,32'h8,       0,32'h0,       32'h0,        1);
        vt[13] = mk(0,0,32'h0,       0,32'h0,       0, 1,32'h8,       0,32'h0,       32'h0,        1);
        vt[14] = mk(1,0,32'h0,       0,32'h0,       0, 1,32'h8,       0,32'h0,       32'h0,        0);
        vt[15] = mk(0,0,32'h0,       1,32'h43,      0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[16] = mk(0,1,32'hDEADBEEF,0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[17] = mk(1,0,32'h0,       1,32'h100,     0, 1,32'h40,      0,32'h0,       32'h0,        0);
        vt[18] = mk(0,1,32'hDEADBEEF,0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[19] = mk(1,0,32'h0,       0,32'h0,       0, 1,32'h100,     0,32'h0,       32'h0,        0);
        vt[20] = mk(0,1,32'h22222222,0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[21] = mk(0,0,32'h0,       1,32'hFFFFFFFE,1, 0,32'h0,       1,32'h22222222,32'h100,      0);
        vt[22] = mk(1,0,32'h0,       0,32'h0,       0, 1,32'hFFFFFFFC,0,32'h0,       32'h0,        0);
        vt[23] = mk(0,1,32'h33333333,0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,        1);
        vt[24] = mk(0,0,32'h0,       0,32'h0,       1, 0,32'h0,       1,32'h33333333,32'hFFFFFFFC, 0);
        vt[25] = mk(0,0,32'h0,       0,32'h0,       0, 1,32'h0,       0,32'h0,       32'h0,        1);

        // Reset state.
        reset = 1'b0;
        drive_zero();
        #2;
        chk("rst_req",   imem_req,    0);
        chk("rst_valid", if_valid,    0);
        chk("rst_instr", if_instr,    0);
        chk("rst_pc",    if_pc,       0);
        chk("rst_pc4",   if_pc_plus4, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall", stall_cnt,   0);
        exp_st = 0;
`endif
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i == 0) reset = 1'b1;
            imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv; imem_rdata = vt[i].rd;
            redirect = vt[i].rr; redirect_pc = vt[i].rp; id_ready = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
            if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), if_valid, vt[i].e_vld);
            if (vt[i].e_vld) begin
                chk($sformatf("vec%0d_instr", i), if_instr, vt[i].e_instr);
                chk($sformatf("vec%0d_pc", i), if_pc, vt[i].e_pc);
                chk($sformatf("vec%0d_pc4", i), if_pc_plus4, vt[i].e_pc + 32'd4);
            end
`ifdef FETCH_STALL_CNT_EN
            chk($sformatf("vec%0d_stall", i), stall_cnt, exp_st);
            exp_st = exp_st + 32'(vt[i].stl);
`endif
        end

        // Reset asserted while a request is in flight; a late response is ignored.
        @(negedge clk);
        drive_zero();
        imem_gnt = 1;
        @(negedge clk);
        drive_zero();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req",   imem_req, 0);
        chk("midrst_valid", if_valid, 0);
        chk("midrst_instr", if_instr, 0);
        chk("midrst_pc",    if_pc,    0);
        @(negedge clk);
        reset = 1'b1;
        imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
        #1;
        chk("postrst_idle_req", imem_req, 0);
        @(negedge clk);
        imem_rvalid = 0; imem_gnt = 1;
        #1;
        chk("postrst_req",   imem_req,  1);
        chk("postrst_addr",  imem_addr, 32'h0);
        chk("postrst_valid", if_valid,  0);
        @(negedge clk);
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h44444444;
        @(negedge clk);
        imem_rvalid = 0;
        #1;
        chk("postrst_out_valid", if_valid, 1);
        chk("postrst_out_instr", if_instr, 32'h44444444);
        chk("postrst_out_pc",    if_pc,    32'h0);

        // Randomized run against a transaction-level model.
        reset = 1'b0;
        drive_zero();
        @(negedge clk);
        reset = 1'b1;
`ifdef FETCH_STALL_CNT_EN
        exp_st = 0;
`endif
        exp_pc = 32'h0; pending = 0; dly = 0; paddr = 0;
        prev_hold = 0; prev_addr = 0; ndel = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
            if (pending) begin
                if (dly == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = memf(paddr);
                end
            end else if (imem_req) begin
                imem_gnt = ($urandom_range(0, 2) != 0);
            end
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            id_ready    = 1'($urandom_range(0, 1));
            #1;
            if (imem_req) begin
                chk("rnd_single_outstanding", pending, 0);
                chk("rnd_req_addr", imem_addr, exp_pc);
            end
            if (prev_hold) begin
                chk("rnd_req_hold", imem_req, 1);
                chk("rnd_addr_hold", imem_addr, prev_addr);
            end
            if (if_valid && id_ready) begin
                chk("rnd_if_pc", if_pc, exp_pc);
                chk("rnd_if_instr", if_instr, memf(exp_pc));
                chk("rnd_if_pc4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                ndel++;
            end
`ifdef FETCH_STALL_CNT_EN
            chk("rnd_stall", stall_cnt, exp_st);
            if ((imem_req && !imem_gnt) || pending || (if_valid && !id_ready))
                exp_st = exp_st + 32'd1;
`endif
            if (redirect) exp_pc = redirect_pc & ~32'd3;
            prev_hold = imem_req && !imem_gnt && !redirect;
            prev_addr = imem_addr;
            if (pending) begin
                if (dly == 0) pending = 0;
                else dly--;
            end else if (imem_req && imem_gnt) begin
                pending = 1;
                paddr   = imem_addr;
                dly     = $urandom_range(0, 2);
            end
        end
        chk("rnd_progress", 32'(ndel > 50), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
